spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter LEAD, default 1: cycles SS_n is low before the first MOSI bit (range 1..15).
REQ-002 SHALL have parameter TURN, default 1: cycles between the last MOSI bit and the first MISO sample on read-data frames (range 1..15).
REQ-003 SHALL have parameter GAP, default 1: minimum cycles SS_n stays high between frames (range 1..15).
REQ-004 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1: request present.
REQ-007 SHALL have port req_ready, output, 1: block can accept a request.
REQ-008 SHALL have port req_cmd, input, 2: 00 write address, 01 write data, 10 read address, 11 read data.
REQ-009 SHALL have port req_data, input, 8: payload (address or data; ignored content for 11, still shifted).
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle pulse, read byte available.
REQ-011 SHALL have port rsp_data, output, 8: byte returned by the slave.
REQ-012 SHALL have port SS_n, output, 1: active-low slave select to the SPI slave.
REQ-013 SHALL have port MOSI, output, 1: serial data to the slave.
REQ-014 SHALL have port MISO, input, 1: serial data from the slave.
REQ-015 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LEAD, SHIFT_TX, TURN, SHIFT_RX, GAP.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-018 SHALL, on acceptance, register frame = {req_cmd, req_data} (10 bits) and go to LEAD; later changes on req_* are ignored until the next IDLE.
REQ-019 SHALL drive SS_n=0 in LEAD, SHIFT_TX, TURN, SHIFT_RX, and SS_n=1 in IDLE and GAP (registered output).
REQ-020 SHALL hold LEAD for exactly LEAD cycles with MOSI=0, then enter SHIFT_TX.
REQ-021 SHALL in SHIFT_TX drive frame bits MSB first, bit 9 down to bit 0, one bit per cycle, exactly 10 cycles.
REQ-022 SHALL, after bit 0, go to GAP if cmd != 11, else to TURN.
REQ-023 SHALL hold TURN for exactly TURN cycles with MOSI=0, then enter SHIFT_RX.
REQ-024 SHALL in SHIFT_RX sample MISO on 8 consecutive rising edges, shifting in MSB first (first sample is rsp_data[7]), MOSI=0.
REQ-025 SHALL, on the edge of the 8th sample, update rsp_data, assert rsp_valid for exactly one cycle, and enter GAP.
REQ-026 SHALL hold rsp_data stable until the next completed read-data frame.
REQ-027 SHALL hold GAP for exactly GAP cycles, then return to IDLE; no request is accepted during GAP.
REQ-028 SHALL NOT provide backpressure on rsp_valid; the consumer must take the byte in the pulse cycle.
REQ-029 SHALL use a single 4-bit down-counter shared by LEAD, SHIFT_TX, TURN, SHIFT_RX and GAP, reloaded on each state entry.
REQ-030 SHALL drive MOSI=0 in IDLE and GAP.
REQ-031 SHALL allow back-to-back frames: with req_valid held high, the next frame is accepted in the first IDLE cycle after GAP.
REQ-032 SHALL, for write-type and read-address frames (cmd 00, 01, 10), keep SS_n low for LEAD+10 cycles.
REQ-033 SHALL, for read-data frames (cmd 11), keep SS_n low for LEAD+10+TURN+8 cycles.

Reset
REQ-034 SHALL, while rst_n=0, immediately force state=IDLE, SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0x00, busy=0, req_ready=0, counter=0.
REQ-035 SHALL abort any frame in progress on reset without producing rsp_valid, and assert req_ready on the first rising edge after rst_n deasserts.

Verification
REQ-036 SHALL pass this scenario: cmd=00, data=0x12, defaults -> SS_n low 11 cycles, 1 lead cycle MOSI=0, then MOSI 0,0,0,0,0,1,0,0,1,0; SS_n high 1 cycle; no rsp_valid.
REQ-037 SHALL pass this scenario: cmd=11, slave returns 0xA5 on MISO from the 2nd cycle after the last MOSI bit -> rsp_data=0xA5, rsp_valid pulses once, SS_n low 20 cycles.
REQ-038 SHALL pass this scenario: req_valid held high with cmd=10 then cmd=11 -> two frames separated by exactly GAP=1 high cycle of SS_n; req_ready high only in IDLE cycles.
REQ-039 SHALL pass this scenario: rst_n pulsed low mid-SHIFT_RX -> SS_n=1 asynchronously, no rsp_valid, rsp_data=0x00, next frame proceeds normally.
REQ-040 SHALL pass this scenario: req_* changed while busy -> the in-flight frame's MOSI bits are unchanged and the change is not accepted.
REQ-041 SHALL pass this scenario: LEAD=3, TURN=2, GAP=4 with cmd=11 -> SS_n low 23 cycles, then high 4 cycles before req_ready.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_if
//   Request/response bundle between a byte-level requester and the SPI
//   master controller.
//
//   req_valid  requester -> ctrl  request present
//   req_ready  ctrl -> requester  controller idle and able to accept
//   req_cmd    requester -> ctrl  00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   req_data   requester -> ctrl  payload byte
//   rsp_valid  ctrl -> requester  one-cycle pulse, read byte available
//   rsp_data   ctrl -> requester  last byte read from the slave
// ---------------------------------------------------------------------------
interface spi_master_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    // Requester side.
    modport master (
        output req_valid, req_cmd, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    // Controller side.
    modport slave (
        input  req_valid, req_cmd, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
//   Frames a 10-bit {cmd, data} word onto a SPI-like link. SS_n drops for a
//   LEAD-cycle lead-in, the frame shifts out MSB first on MOSI, and for
//   read-data frames (cmd 11) a TURN-cycle turnaround is followed by eight
//   MISO samples that form the returned byte. SS_n then stays high for at
//   least GAP cycles before the next request can be accepted.
//
//   Parameters: LEAD, TURN, GAP  (1..15 cycles each)
//
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     request/response bundle (slave modport)
//   SS_n    active-low slave select
//   MOSI    serial data to the slave
//   MISO    serial data from the slave
//   busy    high whenever the controller is not idle
// ---------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int unsigned LEAD = 1,
    parameter int unsigned TURN = 1,
    parameter int unsigned GAP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_ctrl_if.slave   bus,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO,
    output logic               busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT_TX,
        ST_TURN,
        ST_SHIFT_RX,
        ST_GAP
    } state_t;

    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // The shared counter is loaded with (length - 1) and the state is left
    // on the cycle it reads zero, so each phase lasts exactly its length.
    localparam logic [3:0] LEAD_LOAD = 4'(LEAD - 1);
    localparam logic [3:0] TURN_LOAD = 4'(TURN - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);
    localparam logic [3:0] TX_LOAD   = 4'd9;
    localparam logic [3:0] RX_LOAD   = 4'd7;

    state_t     state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic [9:0] frame_q,     frame_d;
    logic [6:0] rx_sh_q,     rx_sh_d;
    logic [7:0] rsp_data_q,  rsp_data_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       ss_n_q,      ss_n_d;
    logic       mosi_q,      mosi_d;
    logic       busy_q,      busy_d;
    logic       req_ready_q, req_ready_d;

    // Next-state and next-output logic. Outputs are derived from the next
    // state so that the registered pins line up with the state they belong to.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        rx_sh_d     = rx_sh_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    frame_d = {bus.req_cmd, bus.req_data};
                    state_d = ST_LEAD;
                    cnt_d   = LEAD_LOAD;
                end
            end
            ST_LEAD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_SHIFT_TX;
                    cnt_d   = TX_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SHIFT_TX: begin
                if (cnt_q == 4'd0) begin
                    if (frame_q[9:8] == CMD_RD_DATA) begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_SHIFT_RX;
                    cnt_d   = RX_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SHIFT_RX: begin
                rx_sh_d = {rx_sh_q[5:0], MISO};
                if (cnt_q == 4'd0) begin
                    // Eighth sample completes the byte directly into rsp_data.
                    rsp_data_d  = {rx_sh_q, MISO};
                    rsp_valid_d = 1'b1;
                    state_d     = ST_GAP;
                    cnt_d       = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        ss_n_d      = !(state_d inside {ST_LEAD, ST_SHIFT_TX, ST_TURN, ST_SHIFT_RX});
        // In SHIFT_TX the counter doubles as the frame bit index (9 down to 0).
        mosi_d      = (state_d == ST_SHIFT_TX) ? frame_d[cnt_d] : 1'b0;
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            frame_q     <= 10'd0;
            rx_sh_q     <= 7'd0;
            rsp_data_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            // Held low in reset so the first post-reset edge is what opens
            // the controller for requests.
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            rx_sh_q     <= rx_sh_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign SS_n          = ss_n_q;
    assign MOSI          = mosi_q;
    assign busy          = busy_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
//   Directed bench for spi_master_ctrl. Instance A uses default timing,
//   instance B uses LEAD=3, TURN=2, GAP=4. A small slave model drives MISO
//   from the SS_n-low cycle count; frames are observed on the falling edge.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       sel;            // 0: instance A, 1: instance B
    logic       req_valid;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       miso;

    int t_lead, t_turn, t_gap;  // timing of the selected instance

    spi_master_ctrl_if bus_a ();
    spi_master_ctrl_if bus_b ();

    logic ss_a, mosi_a, busy_a;
    logic ss_b, mosi_b, busy_b;

    assign bus_a.req_valid = req_valid && !sel;
    assign bus_a.req_cmd   = req_cmd;
    assign bus_a.req_data  = req_data;
    assign bus_b.req_valid = req_valid && sel;
    assign bus_b.req_cmd   = req_cmd;
    assign bus_b.req_data  = req_data;

    spi_master_ctrl u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave),
        .SS_n  (ss_a),
        .MOSI  (mosi_a),
        .MISO  (miso),
        .busy  (busy_a)
    );

    spi_master_ctrl #(.LEAD(3), .TURN(2), .GAP(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave),
        .SS_n  (ss_b),
        .MOSI  (mosi_b),
        .MISO  (miso),
        .busy  (busy_b)
    );

    // Selected-instance view.
    logic       ss, mosi, busy, ready, rv;
    logic [7:0] rsp;
    assign ss    = sel ? ss_b            : ss_a;
    assign mosi  = sel ? mosi_b          : mosi_a;
    assign busy  = sel ? busy_b          : busy_a;
    assign ready = sel ? bus_b.req_ready : bus_a.req_ready;
    assign rv    = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign rsp   = sel ? bus_b.rsp_data  : bus_a.rsp_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_rsp [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and follow the frame through to the next IDLE cycle.
    // After acceptance req_cmd/req_data are moved to nxt_* (and req_valid is
    // kept high if keep_valid) to show in-flight frames ignore them.
    // abort_at > 0 pulls reset during that SS_n-low cycle and returns.
    task automatic run_frame(input string tag, input logic [1:0] cmd, input logic [7:0] data,
                             input logic [7:0] sbyte, input bit keep_valid,
                             input logic [1:0] nxt_cmd, input logic [7:0] nxt_data,
                             input bit exp_immediate, input int abort_at);
        int         waitc, low, gapc, guard, idx;
        int         rvc, rdy_busy, quiet_bad, busy_bad, ss_bad;
        logic [9:0] tx;
        logic [7:0] got_rsp;
        bit         is_rd;

        is_rd     = (cmd == 2'b11);
        tx        = '0;
        got_rsp   = '0;
        rvc       = 0;
        rdy_busy  = 0;
        quiet_bad = 0;
        busy_bad  = 0;
        ss_bad    = 0;

        req_cmd   = cmd;
        req_data  = data;
        req_valid = 1'b1;
        waitc     = 0;
        while (ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "_ready"}, 32'(ready), 32'd1);
        if (exp_immediate) check({tag, "_idle_wait"}, 32'(waitc), 32'd0);

        @(posedge clk);
        @(negedge clk);
        req_cmd  = nxt_cmd;
        req_data = nxt_data;
        if (!keep_valid) req_valid = 1'b0;

        low   = 0;
        guard = 0;
        while (ss === 1'b0 && guard < 100) begin
            low++;
            guard++;
            if (ready)  rdy_busy++;
            if (rv)     rvc++;
            if (!busy)  busy_bad++;
            if (low <= t_lead) begin
                if (mosi !== 1'b0) quiet_bad++;
            end else if (low <= t_lead + 10) begin
                tx = {tx[8:0], mosi};
            end else if (mosi !== 1'b0) begin
                quiet_bad++;
            end
            idx  = low - (t_lead + 10 + t_turn);
            miso = (idx >= 1 && idx <= 8) ? sbyte[8 - idx] : 1'b1;
            if (abort_at == low) begin
                #2 rst_n = 1'b0;
                #1;
                check({tag, "_rst_ss"},    32'(ss),    32'd1);
                check({tag, "_rst_mosi"},  32'(mosi),  32'd0);
                check({tag, "_rst_rv"},    32'(rv),    32'd0);
                check({tag, "_rst_rsp"},   32'(rsp),   32'h00);
                check({tag, "_rst_busy"},  32'(busy),  32'd0);
                check({tag, "_rst_ready"}, 32'(ready), 32'd0);
                exp_rsp[0] = 8'h00;
                exp_rsp[1] = 8'h00;
                miso = 1'b1;
                return;
            end
            @(negedge clk);
        end

        gapc  = 0;
        guard = 0;
        while (ready !== 1'b1 && guard < 40) begin
            guard++;
            gapc++;
            if (rv) begin
                rvc++;
                got_rsp = rsp;
            end
            if (ss !== 1'b1)   ss_bad++;
            if (mosi !== 1'b0) quiet_bad++;
            if (!busy)         busy_bad++;
            miso = 1'b1;
            @(negedge clk);
        end

        if (is_rd) exp_rsp[sel] = sbyte;

        check({tag, "_ss_low"},    32'(low),       32'(t_lead + 10 + (is_rd ? t_turn + 8 : 0)));
        check({tag, "_mosi"},      32'(tx),        32'({cmd, data}));
        check({tag, "_quiet"},     32'(quiet_bad), 32'd0);
        check({tag, "_ready_busy"},32'(rdy_busy),  32'd0);
        check({tag, "_busy"},      32'(busy_bad),  32'd0);
        check({tag, "_gap_ss"},    32'(ss_bad),    32'd0);
        check({tag, "_gap"},       32'(gapc),      32'(t_gap));
        check({tag, "_rv_count"},  32'(rvc),       32'(is_rd ? 1 : 0));
        if (is_rd) check({tag, "_rv_data"}, 32'(got_rsp), 32'(sbyte));
        check({tag, "_rsp_hold"},  32'(rsp),       32'(exp_rsp[sel]));
        check({tag, "_idle_busy"}, 32'(busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel        = 1'b0;
        t_lead     = 1;
        t_turn     = 1;
        t_gap      = 1;
        req_valid  = 1'b0;
        req_cmd    = 2'b00;
        req_data   = 8'h00;
        miso       = 1'b1;
        exp_rsp[0] = 8'h00;
        exp_rsp[1] = 8'h00;
        rst_n      = 1'b1;

        // Reset values, applied asynchronously before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_ss",    32'(ss),    32'd1);
        check("reset_mosi",  32'(mosi),  32'd0);
        check("reset_rv",    32'(rv),    32'd0);
        check("reset_rsp",   32'(rsp),   32'h00);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("reset_ready_first_edge", 32'(ready), 32'd1);

        // Write address 0x12: MOSI 0,0,0,0,0,1,0,0,1,0.
        run_frame("wr_addr", 2'b00, 8'h12, 8'h00, 1'b0, 2'b11, 8'hFF, 1'b0, 0);
        // Read data, slave returns 0xA5; SS_n low 20 cycles.
        run_frame("rd_a5",   2'b11, 8'h3C, 8'hA5, 1'b0, 2'b00, 8'h00, 1'b0, 0);
        // Write data; rsp_data must keep 0xA5.
        run_frame("wr_data", 2'b01, 8'h5A, 8'h00, 1'b0, 2'b10, 8'hA5, 1'b0, 0);

        // Back-to-back with req_valid held high: the second request is
        // presented while the first is in flight and taken in the first IDLE.
        run_frame("b2b_rd_addr", 2'b10, 8'h81, 8'h00, 1'b1, 2'b11, 8'h00, 1'b0, 0);
        run_frame("b2b_rd_data", 2'b11, 8'h00, 8'h3C, 1'b0, 2'b01, 8'hEE, 1'b1, 0);

        // Reset in the middle of SHIFT_RX (cycle 16 of 20).
        run_frame("abort", 2'b11, 8'h44, 8'hC3, 1'b0, 2'b00, 8'h00, 1'b0, 16);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rv", 32'(rv), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_first_edge", 32'(ready), 32'd1);
        check("abort_rsp_cleared",      32'(rsp),   32'h00);

        run_frame("post_rst_rd_addr", 2'b10, 8'hC3, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 0);
        run_frame("post_rst_rd_data", 2'b11, 8'h7E, 8'h96, 1'b0, 2'b00, 8'h00, 1'b0, 0);

        // Non-default timing: LEAD=3, TURN=2, GAP=4.
        @(negedge clk);
        sel    = 1'b1;
        t_lead = 3;
        t_turn = 2;
        t_gap  = 4;
        run_frame("b_rd_data", 2'b11, 8'h77, 8'h5E, 1'b0, 2'b10, 8'h11, 1'b0, 0);
        run_frame("b_wr_addr", 2'b00, 8'hF0, 8'h00, 1'b0, 2'b11, 8'h0F, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
